// File: rtl/clock_pkg.sv
// Shared alarm-clock definitions: FSM encoding, field limits and wrap helpers.
// The SNOOZE encoding exists only when ALARM_CTRL_SNOOZE_EN is defined.
package clock_pkg;

  localparam logic [4:0] HOUR_MAX    = 5'd23;
  localparam logic [5:0] MIN_MAX     = 6'd59;
  localparam logic [4:0] AL_HOUR_RST = 5'd7;
  localparam logic [5:0] AL_MIN_RST  = 6'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SET     = 3'd2,
    ST_RINGING = 3'd3
`ifdef ALARM_CTRL_SNOOZE_EN
    ,
    ST_SNOOZE  = 3'd4
`endif
  } state_t;

  function automatic logic [4:0] inc_hour(input logic [4:0] val);
    return (val >= HOUR_MAX) ? 5'd0 : val + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] val);
    return (val >= MIN_MAX) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 key
// transition; a held key produces no further pulses.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_pulse
);

  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_key;
      r_pulse <= i_key & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm time setting, arming, ringing timeout and optional
// snooze (enabled by defining ALARM_CTRL_SNOOZE_EN).
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       key_mode,
  input  logic       key_next,
  input  logic       key_incr,
  input  logic       key_arm,
  output logic [4:0] al_hour,
  output logic [5:0] al_min,
  output logic       al_setting,
  output logic       al_field,
  output logic       al_armed,
  output logic       ring,
  output logic [2:0] o_dbg_state
);

  localparam logic [9:0] RING_LAST = 10'(RING_SEC - 1);
`ifdef ALARM_CTRL_SNOOZE_EN
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);
`endif

  // Handshake-free interface: key pulses and sec_tick are single-cycle
  // strobes consumed in the cycle they are high; there is no back-pressure.

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_armed;
  logic       w_armed_nxt;
  logic       r_field;
  logic       w_field_nxt;
  logic [4:0] r_hour;
  logic [4:0] w_hour_nxt;
  logic [5:0] r_min;
  logic [5:0] w_min_nxt;
  logic [9:0] r_sec_cnt;
  logic       r_match_prev;
  logic       w_match;
  logic       w_trig;
  logic       w_counting;

  logic w_arm_p, w_mode_p, w_next_p, w_incr_p;
  logic w_arm, w_mode, w_next, w_incr;

  key_edge u_edge_arm  (.clk(clk), .rst(rst), .i_key(key_arm),  .o_pulse(w_arm_p));
  key_edge u_edge_mode (.clk(clk), .rst(rst), .i_key(key_mode), .o_pulse(w_mode_p));
  key_edge u_edge_next (.clk(clk), .rst(rst), .i_key(key_next), .o_pulse(w_next_p));
  key_edge u_edge_incr (.clk(clk), .rst(rst), .i_key(key_incr), .o_pulse(w_incr_p));

  // Only the highest-priority press of a cycle survives.
  assign w_arm  = w_arm_p;
  assign w_mode = w_mode_p & ~w_arm_p;
  assign w_next = w_next_p & ~w_arm_p & ~w_mode_p;
  assign w_incr = w_incr_p & ~w_arm_p & ~w_mode_p & ~w_next_p;

  assign w_match = (cur_hour == r_hour) && (cur_min == r_min) && (cur_sec == 6'd0);
  assign w_trig  = w_match & ~r_match_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_armed_nxt = r_armed;
    w_field_nxt = r_field;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    case (r_state)
      ST_IDLE: begin
        if (w_arm) begin
          w_state_nxt = ST_ARMED;
          w_armed_nxt = 1'b1;
        end else if (w_mode) begin
          w_state_nxt = ST_SET;
          w_field_nxt = 1'b0;
        end
      end
      ST_ARMED: begin
        if (w_arm) begin
          w_state_nxt = ST_IDLE;
          w_armed_nxt = 1'b0;
        end else if (w_mode) begin
          w_state_nxt = ST_SET;
          w_field_nxt = 1'b0;
        end else if (w_trig) begin
          w_state_nxt = ST_RINGING;
        end
      end
      ST_SET: begin
        if (w_arm) begin
          w_armed_nxt = ~r_armed;
        end else if (w_mode) begin
          w_state_nxt = r_armed ? ST_ARMED : ST_IDLE;
        end else if (w_next) begin
          w_field_nxt = ~r_field;
        end else if (w_incr) begin
          if (r_field) w_min_nxt  = inc_min(r_min);
          else         w_hour_nxt = inc_hour(r_hour);
        end
      end
      ST_RINGING: begin
        if (w_arm) begin
          w_state_nxt = ST_IDLE;
          w_armed_nxt = 1'b0;
        end else if (w_next) begin
`ifdef ALARM_CTRL_SNOOZE_EN
          w_state_nxt = ST_SNOOZE;
`else
          w_state_nxt = ST_ARMED;
`endif
        end else if (sec_tick && (r_sec_cnt == RING_LAST)) begin
          w_state_nxt = ST_ARMED;
        end
      end
`ifdef ALARM_CTRL_SNOOZE_EN
      ST_SNOOZE: begin
        if (w_arm) begin
          w_state_nxt = ST_IDLE;
          w_armed_nxt = 1'b0;
        end else if (sec_tick && (r_sec_cnt == SNOOZE_LAST)) begin
          w_state_nxt = ST_RINGING;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_armed_nxt = 1'b0;
      end
    endcase
  end

`ifdef ALARM_CTRL_SNOOZE_EN
  assign w_counting = (r_state == ST_RINGING) || (r_state == ST_SNOOZE);
`else
  assign w_counting = (r_state == ST_RINGING);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_field      <= 1'b0;
      r_hour       <= AL_HOUR_RST;
      r_min        <= AL_MIN_RST;
      r_sec_cnt    <= 10'd0;
      r_match_prev <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_armed      <= w_armed_nxt;
      r_field      <= w_field_nxt;
      r_hour       <= w_hour_nxt;
      r_min        <= w_min_nxt;
      r_match_prev <= w_match;
      // Every state entry restarts the second count from zero.
      if (r_state != w_state_nxt)
        r_sec_cnt <= 10'd0;
      else if (sec_tick && w_counting)
        r_sec_cnt <= r_sec_cnt + 10'd1;
    end
  end

  assign al_hour     = r_hour;
  assign al_min      = r_min;
  assign al_field    = r_field;
  assign al_armed    = r_armed;
  assign al_setting  = (r_state == ST_SET);
  assign ring        = (r_state == ST_RINGING);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: key-sequence vector table plus
// hand-written ring, snooze and reset sequences (RING_SEC=3, SNOOZE_SEC=2).
module tb_alarm_ctrl;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic [4:0] cur_hour = 5'd12;
  logic [5:0] cur_min = 6'd34;
  logic [5:0] cur_sec = 6'd56;
  logic       key_mode = 1'b0, key_next = 1'b0, key_incr = 1'b0, key_arm = 1'b0;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic       al_setting, al_field, al_armed, ring;
  logic [2:0] o_dbg_state;

  alarm_ctrl #(.RING_SEC(3), .SNOOZE_SEC(2)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .key_mode(key_mode), .key_next(key_next), .key_incr(key_incr), .key_arm(key_arm),
    .al_hour(al_hour), .al_min(al_min), .al_setting(al_setting), .al_field(al_field),
    .al_armed(al_armed), .ring(ring), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // {state[2:0], hour[4:0], min[5:0], setting, field, armed, ring}
  localparam int W = 18;
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]   keys;  // {arm, mode, next, incr}
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [4:0] h,
                                      input logic [5:0] m, input logic s, input logic f,
                                      input logic a, input logic r);
    return {st, h, m, s, f, a, r};
  endfunction

  function automatic logic [W-1:0] obs();
    return {o_dbg_state, al_hour, al_min, al_setting, al_field, al_armed, ring};
  endfunction

  task automatic check(input string name);
    logic [W-1:0] e, a;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: actual=empty-queue required=expected-entry", name);
    end else begin
      e = exp_q.pop_front();
      a = obs();
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: actual=%h required=%h", name, a, e);
      end
    end
  endtask

  task automatic expect_now(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    check(name);
  endtask

  task automatic add(input logic [3:0] k, input logic [W-1:0] e);
    vec_t v;
    v.keys = k;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Keys high for one cycle, then two cycles for the edge register and FSM.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    {key_arm, key_mode, key_next, key_incr} = k;
    @(negedge clk);
    {key_arm, key_mode, key_next, key_incr} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic retrigger();
    @(negedge clk);
    cur_sec = 6'd1;
    @(negedge clk);
    cur_sec = 6'd0;
    @(negedge clk);
  endtask

  initial begin
    // Set-mode walk, wraps and same-cycle priority.
    add(4'b0100, mk(ST_SET, 5'd7, 6'd0, 1, 0, 0, 0));
    add(4'b0001, mk(ST_SET, 5'd8, 6'd0, 1, 0, 0, 0));
    add(4'b0001, mk(ST_SET, 5'd9, 6'd0, 1, 0, 0, 0));
    add(4'b0001, mk(ST_SET, 5'd10, 6'd0, 1, 0, 0, 0));
    add(4'b0010, mk(ST_SET, 5'd10, 6'd0, 1, 1, 0, 0));
    add(4'b0001, mk(ST_SET, 5'd10, 6'd1, 1, 1, 0, 0));
    add(4'b0001, mk(ST_SET, 5'd10, 6'd2, 1, 1, 0, 0));
    add(4'b0100, mk(ST_IDLE, 5'd10, 6'd2, 0, 1, 0, 0));
    add(4'b0100, mk(ST_SET, 5'd10, 6'd2, 1, 0, 0, 0));
    for (int i = 11; i <= 23; i++) add(4'b0001, mk(ST_SET, 5'(i), 6'd2, 1, 0, 0, 0));
    add(4'b0001, mk(ST_SET, 5'd0, 6'd2, 1, 0, 0, 0));
    add(4'b0010, mk(ST_SET, 5'd0, 6'd2, 1, 1, 0, 0));
    for (int i = 3; i <= 59; i++) add(4'b0001, mk(ST_SET, 5'd0, 6'(i), 1, 1, 0, 0));
    add(4'b0001, mk(ST_SET, 5'd0, 6'd0, 1, 1, 0, 0));
    add(4'b1000, mk(ST_SET, 5'd0, 6'd0, 1, 1, 1, 0));
    add(4'b1100, mk(ST_SET, 5'd0, 6'd0, 1, 1, 0, 0));
    add(4'b1000, mk(ST_SET, 5'd0, 6'd0, 1, 1, 1, 0));
    add(4'b0100, mk(ST_ARMED, 5'd0, 6'd0, 0, 1, 1, 0));
    add(4'b0100, mk(ST_SET, 5'd0, 6'd0, 1, 0, 1, 0));
    add(4'b0011, mk(ST_SET, 5'd0, 6'd0, 1, 1, 1, 0));
    add(4'b0100, mk(ST_ARMED, 5'd0, 6'd0, 0, 1, 1, 0));
    add(4'b1000, mk(ST_IDLE, 5'd0, 6'd0, 0, 1, 0, 0));
    add(4'b0011, mk(ST_IDLE, 5'd0, 6'd0, 0, 1, 0, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_now("reset", mk(ST_IDLE, 5'd7, 6'd0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      press(vecs[i].keys);
      check($sformatf("vec%0d", i));
    end

    // A held key increments once only.
    press(4'b0100);
    expect_now("hold_enter", mk(ST_SET, 5'd0, 6'd0, 1, 0, 0, 0));
    @(negedge clk);
    key_incr = 1'b1;
    repeat (6) @(negedge clk);
    key_incr = 1'b0;
    @(negedge clk);
    expect_now("hold_incr", mk(ST_SET, 5'd1, 6'd0, 1, 0, 0, 0));

    // Ring timeout.
    do_reset();
    expect_now("reset2", mk(ST_IDLE, 5'd7, 6'd0, 0, 0, 0, 0));
    cur_hour = 5'd6; cur_min = 6'd59; cur_sec = 6'd59;
    press(4'b1000);
    expect_now("armed", mk(ST_ARMED, 5'd7, 6'd0, 0, 0, 1, 0));
    @(negedge clk);
    cur_hour = 5'd7; cur_min = 6'd0; cur_sec = 6'd0;
    @(negedge clk);
    expect_now("ring_on", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    tick();
    expect_now("ring_tick1", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    tick();
    expect_now("ring_tick2", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    tick();
    expect_now("ring_timeout", mk(ST_ARMED, 5'd7, 6'd0, 0, 0, 1, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_now("single_trigger", mk(ST_ARMED, 5'd7, 6'd0, 0, 0, 1, 0));
    end

    // Mode ignored while ringing, then key_next stops the ring.
    retrigger();
    expect_now("ring_again", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    press(4'b0100);
    expect_now("mode_ignored", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    press(4'b0010);
`ifdef ALARM_CTRL_SNOOZE_EN
    expect_now("snooze_enter", mk(ST_SNOOZE, 5'd7, 6'd0, 0, 0, 1, 0));
    tick();
    expect_now("snooze_tick1", mk(ST_SNOOZE, 5'd7, 6'd0, 0, 0, 1, 0));
    tick();
    expect_now("snooze_rering", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    tick();
    expect_now("rering_fresh", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    press(4'b1000);
    expect_now("snooze_disarm", mk(ST_IDLE, 5'd7, 6'd0, 0, 0, 0, 0));
`else
    expect_now("next_stop", mk(ST_ARMED, 5'd7, 6'd0, 0, 0, 1, 0));
    tick();
    tick();
    expect_now("no_snooze", mk(ST_ARMED, 5'd7, 6'd0, 0, 0, 1, 0));
    retrigger();
    expect_now("ring_third", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    press(4'b1000);
    expect_now("ring_disarm", mk(ST_IDLE, 5'd7, 6'd0, 0, 0, 0, 0));
`endif

    // Trigger ignored when not armed.
    retrigger();
    expect_now("idle_ignore", mk(ST_IDLE, 5'd7, 6'd0, 0, 0, 0, 0));

    // Asynchronous reset while ringing.
    press(4'b1000);
    retrigger();
    expect_now("ring_pre_rst", mk(ST_RINGING, 5'd7, 6'd0, 0, 0, 1, 1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    expect_now("async_rst", mk(ST_IDLE, 5'd7, 6'd0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_now("post_rst", mk(ST_IDLE, 5'd7, 6'd0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
